// File: rtl/action_fetch.sv
// action_fetch: action-table fetch stage. Buffers incoming {phv, md} pairs,
// looks up a 64-bit action word for pairs addressed to this module and
// inserts it into the metadata before forwarding the pair downstream.
module action_fetch #(
  parameter logic [7:0] LMID       = 8'd7,
  parameter logic [7:0] NMID       = 8'd9,
  parameter int         FIFO_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [255:0]  in_af_md,
  input  logic          in_af_md_wr,
  input  logic [1023:0] in_af_phv,
  input  logic          in_af_phv_wr,
  output logic          out_af_alf,
  output logic [255:0]  out_af_md,
  output logic          out_af_md_wr,
  output logic [1023:0] out_af_phv,
  output logic          out_af_phv_wr,
  input  logic          in_af_alf,
  input  logic          cfg_act_wr,
  input  logic [12:0]   cfg_act_addr,
  input  logic [63:0]   cfg_act_wdata,
  output logic [31:0]   af_hit_count,
  output logic [31:0]   af_pass_count,
  output logic [31:0]   af_drop_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, READ, OUT} state_t;

  state_t          state;

  logic [1279:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   used;
  logic            both_wr;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic            drop;
  logic [1279:0]   head;

  logic [63:0]     act_mem [8192];
  logic [63:0]     act_dout;
  logic [12:0]     rd_addr;

  logic [255:0]    hold_md;
  logic [1023:0]   hold_phv;
  logic            match;
  logic [255:0]    act_md;

  // A pair is accepted only when both strobes agree and there is room;
  // anything else arriving on the strobes is discarded and counted.
  assign both_wr    = in_af_md_wr && in_af_phv_wr;
  assign fifo_full  = (used == CW'(FIFO_DEPTH));
  assign fifo_empty = (used == '0);
  assign push       = both_wr && !fifo_full;
  assign drop       = (in_af_md_wr != in_af_phv_wr) || (both_wr && fifo_full);
  assign pop        = (state == IDLE) && !fifo_empty && !in_af_alf;
  assign head       = fifo_mem[rd_ptr];
  assign rd_addr    = head[63:51];
  assign out_af_alf = (used >= CW'(FIFO_DEPTH - 2));

  assign match = (hold_md[87:80] == LMID) && hold_md[50];

  // Build the rewritten metadata for a matched pair; the ID byte lies inside
  // the action field, so it is overwritten after the action word is placed.
  always_comb begin
    act_md          = hold_md;
    act_md[127:64]  = act_dout;
    act_md[87:80]   = NMID;
    act_md[50]      = 1'b0;
  end

  // Pair storage; data words need no reset because pointers gate validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {in_af_phv, in_af_md};
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   used <= used + 1'b1;
        2'b01:   used <= used - 1'b1;
        default: used <= used;
      endcase
    end
  end

  // Action table: read-first single-clock RAM, contents survive reset.
  always_ff @(posedge clk) begin
    if (cfg_act_wr) begin
      act_mem[cfg_act_addr] <= cfg_act_wdata;
    end
    if (pop) begin
      act_dout <= act_mem[rd_addr];
    end
  end

  // Discarded-pair counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      af_drop_count <= '0;
    end else if (drop) begin
      af_drop_count <= af_drop_count + 32'd1;
    end
  end

  // Fetch FSM: pop into hold registers, classify and build outputs, then pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      hold_md       <= '0;
      hold_phv      <= '0;
      out_af_md     <= '0;
      out_af_phv    <= '0;
      out_af_md_wr  <= 1'b0;
      out_af_phv_wr <= 1'b0;
      af_hit_count  <= '0;
      af_pass_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            hold_md  <= head[255:0];
            hold_phv <= head[1279:256];
            state    <= READ;
          end
        end
        READ: begin
          if (match) begin
            out_af_md    <= act_md;
            af_hit_count <= af_hit_count + 32'd1;
          end else begin
            out_af_md     <= hold_md;
            af_pass_count <= af_pass_count + 32'd1;
          end
          out_af_phv    <= hold_phv;
          out_af_md_wr  <= 1'b1;
          out_af_phv_wr <= 1'b1;
          state         <= OUT;
        end
        OUT: begin
          out_af_md_wr  <= 1'b0;
          out_af_phv_wr <= 1'b0;
          state         <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_action_fetch.sv
// tb_action_fetch: randomized and directed stimulus with a queue-based
// scoreboard; a negedge monitor pops expectations as output pulses appear.
module tb_action_fetch;

  logic          clk = 1'b0;
  logic          rst;
  logic [255:0]  in_af_md;
  logic          in_af_md_wr;
  logic [1023:0] in_af_phv;
  logic          in_af_phv_wr;
  logic          out_af_alf;
  logic [255:0]  out_af_md;
  logic          out_af_md_wr;
  logic [1023:0] out_af_phv;
  logic          out_af_phv_wr;
  logic          in_af_alf;
  logic          cfg_act_wr;
  logic [12:0]   cfg_act_addr;
  logic [63:0]   cfg_act_wdata;
  logic [31:0]   af_hit_count;
  logic [31:0]   af_pass_count;
  logic [31:0]   af_drop_count;

  action_fetch #(.LMID(8'd7), .NMID(8'd9), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_af_md(in_af_md), .in_af_md_wr(in_af_md_wr),
    .in_af_phv(in_af_phv), .in_af_phv_wr(in_af_phv_wr),
    .out_af_alf(out_af_alf),
    .out_af_md(out_af_md), .out_af_md_wr(out_af_md_wr),
    .out_af_phv(out_af_phv), .out_af_phv_wr(out_af_phv_wr),
    .in_af_alf(in_af_alf),
    .cfg_act_wr(cfg_act_wr), .cfg_act_addr(cfg_act_addr), .cfg_act_wdata(cfg_act_wdata),
    .af_hit_count(af_hit_count), .af_pass_count(af_pass_count), .af_drop_count(af_drop_count)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  typedef struct {
    logic [255:0]  md;
    logic [1023:0] phv;
    int            cyc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [63:0] model_tab [int];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          exp_hit = 0;
  int          exp_pass = 0;
  int          exp_drop = 0;
  int          out_pulses = 0;
  bit          spacing_check = 0;
  int          last_out_cyc = -1;

  // cycle counter: value during a clock period identifies that cycle
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic logic [1023:0] rand_phv();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [255:0] rand_md();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // reference model: matched pairs get the action word and next ID inserted
  task automatic computeExpected(input logic [255:0] md, output logic [255:0] r);
    int idx;
    r = md;
    idx = int'(md[63:51]);
    if (md[87:80] == 8'd7 && md[50] == 1'b1) begin
      r[127:64] = model_tab[idx];
      r[87:80]  = 8'd9;
      r[50]     = 1'b0;
      exp_hit++;
    end else begin
      exp_pass++;
    end
  endtask

  // drive one pair for one cycle; optionally record its expected output
  task automatic applyStimulus(input logic [255:0] md, input logic [1023:0] phv,
                               input bit expect_out, input int latency);
    exp_t e;
    in_af_md     = md;
    in_af_phv    = phv;
    in_af_md_wr  = 1'b1;
    in_af_phv_wr = 1'b1;
    if (expect_out) begin
      computeExpected(md, e.md);
      e.phv = phv;
      e.cyc = (latency > 0) ? cyc + latency : -1;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    in_af_md_wr  = 1'b0;
    in_af_phv_wr = 1'b0;
  endtask

  task automatic cfgWrite(input logic [12:0] addr, input logic [63:0] data);
    cfg_act_wr    = 1'b1;
    cfg_act_addr  = addr;
    cfg_act_wdata = data;
    model_tab[int'(addr)] = data;
    @(posedge clk); #1;
    cfg_act_wr = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sbq.size() != 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout: %0d outputs still pending, required 0", sbq.size());
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] mk_md(input logic [7:0] id, input logic [12:0] idx, input logic vld);
    logic [255:0] r;
    r = rand_md();
    r[87:80] = id;
    r[63:51] = idx;
    r[50]    = vld;
    return r;
  endfunction

  // monitor: every output pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && (out_af_md_wr || out_af_phv_wr)) begin
      out_pulses++;
      checks++;
      if (out_af_md_wr !== out_af_phv_wr) begin
        errors++;
        $display("[TB] FAIL strobe_pair: md_wr %b phv_wr %b, required equal", out_af_md_wr, out_af_phv_wr);
      end
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_output: pulse at cycle %0d, required none", cyc);
      end else begin
        mon_e = sbq.pop_front();
        checkOutput("out_md", out_af_md, mon_e.md);
        checks++;
        if (out_af_phv !== mon_e.phv) begin
          int w = 0;
          for (int i = 31; i >= 0; i--) if (out_af_phv[i*32 +: 32] !== mon_e.phv[i*32 +: 32]) w = i;
          errors++;
          $display("[TB] FAIL out_phv: word %0d got %h, required %h", w,
                   out_af_phv[w*32 +: 32], mon_e.phv[w*32 +: 32]);
        end
        if (mon_e.cyc >= 0) checkOutput("latency_cycle", 256'(cyc), 256'(mon_e.cyc));
        if (spacing_check && last_out_cyc >= 0) checkOutput("output_spacing", 256'(cyc - last_out_cyc), 256'd3);
        last_out_cyc = cyc;
      end
    end
  end

  initial begin
    int pulses_before;
    rst = 1'b1;
    in_af_md = '0; in_af_md_wr = 1'b0; in_af_phv = '0; in_af_phv_wr = 1'b0;
    in_af_alf = 1'b0; cfg_act_wr = 1'b0; cfg_act_addr = '0; cfg_act_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_md", out_af_md, 256'd0);
    checkOutput("reset_phv", {255'd0, out_af_phv == '0}, 256'd1);
    checkOutput("reset_wr", {254'd0, out_af_md_wr, out_af_phv_wr}, 256'd0);
    checkOutput("reset_alf", {255'd0, out_af_alf}, 256'd0);
    checkOutput("reset_counts", {160'd0, af_hit_count, af_pass_count, af_drop_count}, 256'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // matched pair with exact latency
    cfgWrite(13'h0123, 64'hDEAD_BEEF_0000_0001);
    applyStimulus(mk_md(8'd7, 13'h0123, 1'b1), rand_phv(), 1'b1, 3);
    waitDrain();
    checkOutput("hit_count_1", 256'(af_hit_count), 256'(exp_hit));

    // pass-through: foreign ID and own ID without valid index
    applyStimulus(mk_md(8'd5, 13'($urandom), 1'b1), rand_phv(), 1'b1, 0);
    applyStimulus(mk_md(8'd7, 13'h0123, 1'b0), rand_phv(), 1'b1, 0);
    waitDrain();
    checkOutput("pass_count_2", 256'(af_pass_count), 256'(exp_pass));

    // backpressure: nothing leaves while downstream is almost full
    in_af_alf = 1'b1;
    pulses_before = out_pulses;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(mk_md(8'd7, 13'h0123, 1'($urandom_range(0, 1))), rand_phv(), 1'b1, 0);
      if (i == 4) checkOutput("alf_at_5", {255'd0, out_af_alf}, 256'd0);
    end
    checkOutput("alf_at_6", {255'd0, out_af_alf}, 256'd1);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("no_pulse_held", 256'(out_pulses), 256'(pulses_before));
    spacing_check = 1; last_out_cyc = -1;
    in_af_alf = 1'b0;
    waitDrain();
    spacing_check = 0;

    // overflow: 8 fit, 2 dropped, then one strobe mismatch
    in_af_alf = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(mk_md(8'($urandom), 13'($urandom), 1'b0), rand_phv(), (i < 8), 0);
      if (i >= 8) exp_drop++;
    end
    in_af_md_wr = 1'b1;
    @(posedge clk); #1;
    in_af_md_wr = 1'b0;
    exp_drop++;
    checkOutput("drop_count_3", 256'(af_drop_count), 256'd3);
    in_af_alf = 1'b0;
    waitDrain();

    // config/read collision at address 0x10: old data wins, new data next time
    cfgWrite(13'h0010, 64'hAAAA_0000_1111_2222);
    applyStimulus(mk_md(8'd7, 13'h0010, 1'b1), rand_phv(), 1'b1, 3);
    cfgWrite(13'h0010, 64'hBBBB_3333_4444_5555);
    waitDrain();
    applyStimulus(mk_md(8'd7, 13'h0010, 1'b1), rand_phv(), 1'b1, 3);
    waitDrain();

    // randomized traffic over a preloaded table region
    for (int i = 0; i < 32; i++) cfgWrite(13'h100 + 13'(i), {$urandom, $urandom});
    for (int it = 0; it < 150; it++) begin
      int r;
      int kind;
      in_af_alf = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 9);
      if (r < 6 && !out_af_alf) begin
        kind = $urandom_range(0, 2);
        if (kind == 0) applyStimulus(mk_md(8'd7, 13'h100 + 13'($urandom_range(0, 31)), 1'b1), rand_phv(), 1'b1, 0);
        else if (kind == 1) applyStimulus(mk_md(8'd7, 13'($urandom), 1'b0), rand_phv(), 1'b1, 0);
        else begin
          logic [7:0] id;
          id = 8'($urandom);
          if (id == 8'd7) id = 8'd8;
          applyStimulus(mk_md(id, 13'($urandom), 1'($urandom)), rand_phv(), 1'b1, 0);
        end
      end else if (r == 6) begin
        if ($urandom_range(0, 1) == 0) in_af_md_wr = 1'b1; else in_af_phv_wr = 1'b1;
        exp_drop++;
        @(posedge clk); #1;
        in_af_md_wr = 1'b0; in_af_phv_wr = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
    in_af_alf = 1'b0;
    waitDrain();
    checkOutput("final_hit", 256'(af_hit_count), 256'(exp_hit));
    checkOutput("final_pass", 256'(af_pass_count), 256'(exp_pass));
    checkOutput("final_drop", 256'(af_drop_count), 256'(exp_drop));

    // asynchronous reset while a pair is in READ with 3 more queued
    in_af_alf = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(mk_md(8'd7, 13'h0123, 1'b1), rand_phv(), 1'b0, 0);
    in_af_alf = 1'b0;
    @(posedge clk); #1;
    in_af_alf = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_md", out_af_md, 256'd0);
    checkOutput("async_rst_phv", {255'd0, out_af_phv == '0}, 256'd1);
    checkOutput("async_rst_counts", {160'd0, af_hit_count, af_pass_count, af_drop_count}, 256'd0);
    checkOutput("async_rst_alf_wr", {253'd0, out_af_alf, out_af_md_wr, out_af_phv_wr}, 256'd0);
    exp_hit = 0; exp_pass = 0; exp_drop = 0;
    pulses_before = out_pulses;
    @(negedge clk) rst = 1'b0;
    in_af_alf = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("no_pulse_after_rst", 256'(out_pulses), 256'(pulses_before));
    checkOutput("counts_after_rst", {160'd0, af_hit_count, af_pass_count, af_drop_count}, 256'd0);
    checkOutput("alf_after_rst", {255'd0, out_af_alf}, 256'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
